mtl_timing_gen: RTL and testbench
=================================

# mtl_timing_gen

Raster timing generator for the MTL 800x480 panel path. It free-runs horizontal and vertical counters and drives the pixel coordinates (`Xpos`, `Ypos`) consumed by the colour/pattern blocks. It also drives the panel sync and data-enable signals, delayed by `PIPE_LAT` cycles so they line up with the registered RGB those blocks return. It sits between the pixel-clock domain root and the colour generator, feeding the MTL connector.

## Interface
- `H_ACT`, 800: active pixels per line
- `H_FP`, 210: horizontal front porch, pixels
- `H_SYNC`, 30: hsync pulse width, pixels
- `H_BP`, 16: horizontal back porch, pixels (line total 1056)
- `V_ACT`, 480: active lines per frame
- `V_FP`, 22: vertical front porch, lines
- `V_SYNC`, 13: vsync pulse width, lines
- `V_BP`, 10: vertical back porch, lines (frame total 525)
- `PIPE_LAT`, 1: downstream RGB latency in cycles, range 0..4
- `clk` in 1: pixel clock
- `reset` in 1: asynchronous, active-high; clears all state
- `ce` in 1: pixel enable; when 0 all counters and output registers hold
- `Xpos` out 11: active column 0..H_ACT-1; 0 outside active
- `Ypos` out 10: active row 0..V_ACT-1; 0 outside active
- `active` out 1: coordinate valid, aligned with `Xpos`/`Ypos`
- `de` out 1: panel data enable, `active` delayed `PIPE_LAT` ce-cycles
- `hsync_n` out 1: active-low hsync, delayed `PIPE_LAT`
- `vsync_n` out 1: active-low vsync, delayed `PIPE_LAT`
- `frame_start` out 1: one-ce-cycle pulse at raster origin, delayed `PIPE_LAT`

## Operation
- `h_cnt` (11 b) counts 0..H_TOTAL-1, where H_TOTAL = H_SYNC+H_BP+H_ACT+H_FP. It wraps to 0.
- `v_cnt` (10 b) increments only when `h_cnt` wraps, and counts 0..V_TOTAL-1 with the same sync/back-porch/active/front-porch ordering.
- Horizontal line layout by `h_cnt`:
  - sync: [0, H_SYNC)
  - back porch: [H_SYNC, H_SYNC+H_BP)
  - active: [H_SYNC+H_BP, H_SYNC+H_BP+H_ACT)
  - front porch: remainder
- The vertical frame uses the same layout, indexed by `v_cnt`.
- Frame wrap: when both counters are at their maximum, both go to 0 on the same edge.
- Decode, registered stage 0:
  - `active` = h-active AND v-active
  - `Xpos` = h_cnt − (H_SYNC+H_BP) when active, else 0
  - `Ypos` = v_cnt − (V_SYNC+V_BP) when active, else 0
  - subtraction is unsigned and is only evaluated inside the active window, so it never underflows
  - hsync_raw = h_cnt < H_SYNC
  - vsync_raw = v_cnt < V_SYNC, held for whole lines
  - fs_raw = (h_cnt==0 && v_cnt==0)
- Alignment stage: `active`, hsync_raw, vsync_raw and fs_raw pass through a `PIPE_LAT`-deep shift register, advanced only on `ce`. Its outputs are `de`, inverted `hsync_n`, inverted `vsync_n` and `frame_start`.
- `PIPE_LAT` = 0 makes the alignment stage a pass-through of the stage-0 registers.
- `ce` low: counters, stage-0 registers and the shift register all hold. `frame_start` stays high if it was high; the pulse is one ce-cycle long, not one clk long.
- There is no state machine beyond the counters. Illegal counter values cannot occur because the wrap compares use `>=` max.

## Timing
- Reset values:
  - counters: 0
  - `Xpos`, `Ypos`: 0
  - `active`, `de`, `frame_start`: 0
  - `hsync_n`, `vsync_n`: 1
  - shift register contents: inactive (de=0, syncs deasserted, fs=0)
- Stage-0 outputs on edge k after reset release (ce=1) reflect counter value k−1.
- `de`/syncs/`frame_start` lag stage-0 by exactly `PIPE_LAT` ce-cycles.
- Line period: H_TOTAL ce-cycles. Frame period: H_TOTAL×V_TOTAL ce-cycles (554400 at defaults).
- Reset asserted mid-frame:
  - all outputs go to reset values immediately (asynchronous), including in-flight shift-register contents
  - the raster restarts at origin on release; no partial-frame recovery
- `ce` toggling every cycle (divided pixel clock): the output sequence is identical to ce=1, stretched 2x.

## Test plan
- **Reset release, ce=1, defaults**:
  - first `frame_start`=1 on edge 2 (stage 0 edge 1 + PIPE_LAT 1), one cycle wide
  - `hsync_n` low for edges 2..31
  - `vsync_n` low for 13×1056 = 13728 cycles
- **First active pixel**:
  - `active`=1 with `Xpos`=0, `Ypos`=0 on edge 24335 (counter index 23×1056+46)
  - `de`=1 on edge 24336
  - `Xpos`=799 on edge 25134, then `active`=0 on the next edge
- **Last pixel of frame**:
  - `Xpos`=799, `Ypos`=479 observed
  - next `frame_start` exactly 554400 cycles after the previous one
  - `Ypos` never exceeds 479; `Xpos` never exceeds 799
- **ce pattern 1,0 repeating**:
  - every output transition occurs at twice the ce=1 cycle count
  - `frame_start` high for exactly 2 clk (one ce-cycle)
  - counters hold on ce=0
- **Reset asserted at `Xpos`=400, `Ypos`=200**:
  - same cycle: `de`=0, `hsync_n`=`vsync_n`=1, `Xpos`=`Ypos`=0
  - after release, the sequence matches the first scenario exactly
- **PIPE_LAT=3 rebuild**:
  - `de` rises exactly 3 cycles after `active`
  - `hsync_n` falls 3 cycles after the stage-0 sync decode
  - `frame_start` lags by 3

Source files
------------

// File: rtl/mtl_timing_gen.sv
// Raster timing generator for the MTL 800x480 panel.
// Free-running h/v counters, registered decode and sync alignment.
module mtl_timing_gen #(
  parameter int H_ACT    = 800,
  parameter int H_FP     = 210,
  parameter int H_SYNC   = 30,
  parameter int H_BP     = 16,
  parameter int V_ACT    = 480,
  parameter int V_FP     = 22,
  parameter int V_SYNC   = 13,
  parameter int V_BP     = 10,
  parameter int PIPE_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  output logic [10:0] Xpos,
  output logic [9:0]  Ypos,
  output logic        active,
  output logic        de,
  output logic        hsync_n,
  output logic        vsync_n,
  output logic        frame_start
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACT + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACT + V_FP;

  localparam logic [10:0] H_MAX  = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_SEND = 11'(H_SYNC);
  localparam logic [10:0] H_AST  = 11'(H_SYNC + H_BP);
  localparam logic [10:0] H_AEND = 11'(H_SYNC + H_BP + H_ACT);
  localparam logic [9:0]  V_MAX  = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_SEND = 10'(V_SYNC);
  localparam logic [9:0]  V_AST  = 10'(V_SYNC + V_BP);
  localparam logic [9:0]  V_AEND = 10'(V_SYNC + V_BP + V_ACT);

  logic [10:0] h_cnt;
  logic [9:0]  v_cnt;
  logic        h_act;
  logic        v_act;
  logic        act_nxt;
  logic [10:0] x_nxt;
  logic [9:0]  y_nxt;
  logic        hs0;
  logic        vs0;
  logic        fs0;

  // Raster counters; v advances on h wrap, both wrap together at frame end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (ce) begin
      if (h_cnt >= H_MAX) begin
        h_cnt <= '0;
        if (v_cnt >= V_MAX) v_cnt <= '0;
        else                v_cnt <= v_cnt + 10'd1;
      end else begin
        h_cnt <= h_cnt + 11'd1;
      end
    end
  end

  // Window decode; coordinates only subtracted inside the active window
  always_comb begin
    h_act   = (h_cnt >= H_AST) && (h_cnt < H_AEND);
    v_act   = (v_cnt >= V_AST) && (v_cnt < V_AEND);
    act_nxt = h_act && v_act;
    x_nxt   = '0;
    y_nxt   = '0;
    if (act_nxt) begin
      x_nxt = h_cnt - H_AST;
      y_nxt = v_cnt - V_AST;
    end
  end

  // Stage 0: registered coordinates and raw (active-high) sync flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Xpos   <= '0;
      Ypos   <= '0;
      active <= 1'b0;
      hs0    <= 1'b0;
      vs0    <= 1'b0;
      fs0    <= 1'b0;
    end else if (ce) begin
      Xpos   <= x_nxt;
      Ypos   <= y_nxt;
      active <= act_nxt;
      hs0    <= (h_cnt < H_SEND);
      vs0    <= (v_cnt < V_SEND);
      fs0    <= (h_cnt == '0) && (v_cnt == '0);
    end
  end

  generate
    if (PIPE_LAT == 0) begin : g_pass
      assign de          = active;
      assign hsync_n     = ~hs0;
      assign vsync_n     = ~vs0;
      assign frame_start = fs0;
    end else begin : g_pipe
      logic [PIPE_LAT-1:0] de_sr;
      logic [PIPE_LAT-1:0] hs_sr;
      logic [PIPE_LAT-1:0] vs_sr;
      logic [PIPE_LAT-1:0] fs_sr;

      // Alignment shift register, matches downstream RGB latency
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          de_sr <= '0;
          hs_sr <= '0;
          vs_sr <= '0;
          fs_sr <= '0;
        end else if (ce) begin
          de_sr[0] <= active;
          hs_sr[0] <= hs0;
          vs_sr[0] <= vs0;
          fs_sr[0] <= fs0;
          for (int i = 1; i < PIPE_LAT; i++) begin
            de_sr[i] <= de_sr[i-1];
            hs_sr[i] <= hs_sr[i-1];
            vs_sr[i] <= vs_sr[i-1];
            fs_sr[i] <= fs_sr[i-1];
          end
        end
      end

      assign de          = de_sr[PIPE_LAT-1];
      assign hsync_n     = ~hs_sr[PIPE_LAT-1];
      assign vsync_n     = ~vs_sr[PIPE_LAT-1];
      assign frame_start = fs_sr[PIPE_LAT-1];
    end
  endgenerate

endmodule

// File: tb/tb_mtl_timing_gen.sv
// Bench for mtl_timing_gen: default raster plus two small rasters
// (latency 0 and 3), all compared against an arithmetic raster model.
module tb_mtl_timing_gen;

  typedef struct packed {
    logic [10:0] x;
    logic [9:0]  y;
    logic        act;
    logic        de;
    logic        hs_n;
    logic        vs_n;
    logic        fs;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ce = 1'b0;

  logic [10:0] xd, xa, xb;
  logic [9:0]  yd, ya, yb;
  logic        actd, acta, actb;
  logic        ded, dea, deb;
  logic        hsd, hsa, hsb;
  logic        vsd, vsa, vsb;
  logic        fsd, fsa, fsb;

  int n_checks = 0;
  int n_fail = 0;
  int n = 0;

  always #5 clk = ~clk;

  mtl_timing_gen u_def (
    .clk(clk), .reset(reset), .ce(ce),
    .Xpos(xd), .Ypos(yd), .active(actd), .de(ded),
    .hsync_n(hsd), .vsync_n(vsd), .frame_start(fsd)
  );

  mtl_timing_gen #(
    .H_ACT(8), .H_FP(3), .H_SYNC(2), .H_BP(2),
    .V_ACT(5), .V_FP(2), .V_SYNC(2), .V_BP(1),
    .PIPE_LAT(0)
  ) u_l0 (
    .clk(clk), .reset(reset), .ce(ce),
    .Xpos(xa), .Ypos(ya), .active(acta), .de(dea),
    .hsync_n(hsa), .vsync_n(vsa), .frame_start(fsa)
  );

  mtl_timing_gen #(
    .H_ACT(8), .H_FP(3), .H_SYNC(2), .H_BP(2),
    .V_ACT(5), .V_FP(2), .V_SYNC(2), .V_BP(1),
    .PIPE_LAT(3)
  ) u_l3 (
    .clk(clk), .reset(reset), .ce(ce),
    .Xpos(xb), .Ypos(yb), .active(actb), .de(deb),
    .hsync_n(hsb), .vsync_n(vsb), .frame_start(fsb)
  );

  task automatic check(input string tag, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s at tick %0d: got %0d expected %0d",
                 tag, n, got, want);
    end
  endtask

  // Expected outputs after n ce-advances since reset release.
  // Stage 0 at tick n shows raster index n-1; delayed outputs
  // show raster index n-1-lat; negative indices mean reset state.
  function automatic exp_t ref_out(input int t,
      input int hs, input int hb, input int ha, input int hf,
      input int vs, input int vb, input int va, input int vf,
      input int lat);
    exp_t r;
    int ht, vt, p, h, v, m;
    ht = hs + hb + ha + hf;
    vt = vs + vb + va + vf;
    r = '0;
    r.hs_n = 1'b1;
    r.vs_n = 1'b1;
    if (t >= 1) begin
      p = (t - 1) % (ht * vt);
      h = p % ht;
      v = p / ht;
      if (h >= hs + hb && h < hs + hb + ha &&
          v >= vs + vb && v < vs + vb + va) begin
        r.act = 1'b1;
        r.x = 11'(h - hs - hb);
        r.y = 10'(v - vs - vb);
      end
    end
    m = t - lat;
    if (m >= 1) begin
      p = (m - 1) % (ht * vt);
      h = p % ht;
      v = p / ht;
      r.de = (h >= hs + hb && h < hs + hb + ha &&
              v >= vs + vb && v < vs + vb + va);
      r.hs_n = !(h < hs);
      r.vs_n = !(v < vs);
      r.fs = (p == 0);
    end
    return r;
  endfunction

  task automatic chk_inst(input string tag, input exp_t g, input exp_t e);
    check({tag, ".Xpos"}, int'(g.x), int'(e.x));
    check({tag, ".Ypos"}, int'(g.y), int'(e.y));
    check({tag, ".active"}, int'(g.act), int'(e.act));
    check({tag, ".de"}, int'(g.de), int'(e.de));
    check({tag, ".hsync_n"}, int'(g.hs_n), int'(e.hs_n));
    check({tag, ".vsync_n"}, int'(g.vs_n), int'(e.vs_n));
    check({tag, ".frame_start"}, int'(g.fs), int'(e.fs));
  endtask

  task automatic check_all();
    chk_inst("def", {xd, yd, actd, ded, hsd, vsd, fsd},
             ref_out(n, 30, 16, 800, 210, 13, 10, 480, 22, 1));
    chk_inst("lat0", {xa, ya, acta, dea, hsa, vsa, fsa},
             ref_out(n, 2, 2, 8, 3, 2, 1, 5, 2, 0));
    chk_inst("lat3", {xb, yb, actb, deb, hsb, vsb, fsb},
             ref_out(n, 2, 2, 8, 3, 2, 1, 5, 2, 3));
  endtask

  // Drive at negedge, let one posedge happen, check at next negedge
  task automatic step(input logic ce_v, input logic rst_v);
    ce = ce_v;
    reset = rst_v;
    if (rst_v) begin
      n = 0;
      #1;
      check_all();
    end
    @(posedge clk);
    if (!rst_v && ce_v) n++;
    @(negedge clk);
    check_all();
  endtask

  // Fixed landmarks of the default 800x480 raster
  task automatic landmarks();
    if (n == 1) check("def.fs_edge1", int'(fsd), 0);
    if (n == 2) check("def.fs_edge2", int'(fsd), 1);
    if (n == 3) check("def.fs_edge3", int'(fsd), 0);
    if (n == 31) check("def.hsync_edge31", int'(hsd), 0);
    if (n == 32) check("def.hsync_edge32", int'(hsd), 1);
    if (n == 13729) check("def.vsync_last", int'(vsd), 0);
    if (n == 13730) check("def.vsync_end", int'(vsd), 1);
    if (n == 24334) check("def.act_pre", int'(actd), 0);
    if (n == 24335) begin
      check("def.first_act", int'(actd), 1);
      check("def.first_x", int'(xd), 0);
      check("def.first_y", int'(yd), 0);
      check("def.first_de_pre", int'(ded), 0);
    end
    if (n == 24336) check("def.first_de", int'(ded), 1);
    if (n == 25134) check("def.last_x", int'(xd), 799);
    if (n == 25135) check("def.act_off", int'(actd), 0);
  endtask

  initial begin
    @(negedge clk);
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);

    // Continuous ce through the first active line of the default raster
    for (int i = 0; i < 25200; i++) begin
      step(1'b1, 1'b0);
      landmarks();
    end

    // Mid-run reset, then the same opening sequence again
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 1'b0);
      landmarks();
    end

    // Random ce with occasional reset pulses
    for (int i = 0; i < 8000; i++) begin
      step(logic'($urandom_range(0, 3) != 0),
           logic'($urandom_range(0, 1499) == 0));
    end

    // Divided pixel clock: ce 1,0 repeating from a fresh reset
    step(1'b0, 1'b1);
    for (int i = 0; i < 2000; i++) begin
      step(1'b1, 1'b0);
      if (n == 2) check("def.fs_div_hi", int'(fsd), 1);
      step(1'b0, 1'b0);
      if (n == 2) check("def.fs_div_hold", int'(fsd), 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
